spi_target: RTL
===============

Name: spi_target

Overview:
- Memory-mapped SPI target (slave) peripheral: the far end of the SPI link that the flash controller drives as a controller.
- Lets an external SPI controller on general pins exchange bytes with the picorv32 SoC.
- CPU side is a responder on the SoC valid/ready memory bus. The top level decodes the select, gates valid, ORs ready and muxes rdata.
- Contains an RX FIFO (SPI→CPU) and a TX FIFO (CPU→SPI).

Parameters:
RX_DEPTH, 16, RX FIFO entries; power of two, ≥2
TX_DEPTH, 16, TX FIFO entries; power of two, ≥2
FILL_BYTE, 8'hFF, byte shifted out when TX FIFO is empty at byte start

Ports:
clk  input  1  system clock
resetn  input  1  asynchronous active-low reset
valid  input  1  bus request; already qualified by select
ready  output  1  one-cycle response strobe
wstrb  input  4  byte write strobes; 0 = read
addr  input  32  byte address; only addr[3:2] decoded
wdata  input  32  write data
rdata  output  32  read data; valid while ready=1, else 0
spi_sck  input  1  SPI clock from controller, mode 0
spi_csb  input  1  chip select, active low
spi_mosi  input  1  controller→target data
spi_miso  output  1  target→controller data
spi_miso_oe  output  1  MISO output enable to the pin buffer
irq  output  1  level interrupt

Behaviour:
- Reset, asynchronous on resetn low: ready=0, rdata=0, spi_miso=0, spi_miso_oe=0, irq=0, both FIFOs empty, all flags and CTRL=0, bit counter=0.
- Synchronisation: spi_sck, spi_csb and spi_mosi each pass through a 2-FF synchroniser. Edges are detected in the clk domain.
  - Requires f(sck) ≤ f(clk)/8.
  - SPI response latency is 3 clk cycles after a pin edge.
- Bus handshake:
  - ready=1 on the cycle after valid && !ready, for exactly one cycle.
  - The initiator holds valid until ready.
  - Side effects (push, pop, W1C) occur only on the ready cycle, exactly once per access.
- Register map, word offset addr[3:2]:
  - 0 DATA
    - Read: {23'b0, v, byte}. v=1 means byte was popped from RX. RX empty → v=0, byte=0, no pop.
    - Write with wstrb[0]=1: push wdata[7:0] to TX. TX full → dropped and txdrop flag set.
  - 1 STATUS
    - Read bits: [0] rx_nonempty, [1] tx_empty, [2] tx_full, [3] rxovf, [4] txund, [5] txdrop, [6] csb_active (synchronised), [15:8] rx_count zero-extended.
    - Write: 1s in bits [5:3] clear those flags (W1C).
  - 2 CTRL: RW bits [2:0] = irq enables for rx_nonempty, tx_empty, any error flag (rxovf|txund|txdrop).
  - 3: reads 0, writes ignored.
- Simultaneous events: a CPU pop and an SPI push (or CPU push and SPI pop) in the same cycle are both honoured, and the count is unchanged.
  - A W1C in the same cycle as a flag set: the set wins.
- SPI engine, mode 0, MSB first, 8-bit:
  - spi_miso_oe = synchronised csb low.
  - On csb falling: bit counter=0; load shift-out register from TX pop, or FILL_BYTE with txund set if TX is empty; spi_miso = shift-out[7].
  - On sck rising while selected: shift in mosi; counter+1.
  - On the 8th rising edge:
    - Push the received byte to RX. RX full → byte discarded, rxovf set.
    - Counter wraps to 0.
    - Immediately reload shift-out from TX pop, or FILL_BYTE with txund set.
  - On sck falling edges other than those directly after a reload: shift-out shifts left; spi_miso = new bit 7.
  - csb rising mid-byte: partial RX bits discarded with no push. A TX byte already loaded is consumed and lost. Counter=0.
  - Edges seen while csb is high are ignored.
- irq = |(CTRL[2:0] & {err_any, tx_empty, rx_nonempty}), registered, so there is one clk of latency.

Optional Feature:
- SPI_TARGET_IRQ_EN defined: CTRL register and irq logic present as above.
- SPI_TARGET_IRQ_EN undefined:
  - irq tied 0.
  - CTRL reads 0 and writes are ignored.
  - Flags and STATUS remain functional.

Test Plan:
- Write DATA 0xA5, then the controller clocks 1 byte with mosi=0x3C → miso bits 1010_0101; afterwards DATA read = 0x13C, then the next DATA read = 0x000.
- TX empty at csb fall → miso shifts 0xFF and STATUS[4]=1; write STATUS 0x10 → STATUS[4]=0.
- Controller sends RX_DEPTH+1 bytes with no CPU reads → rx_count=16, rxovf=1, first 16 bytes read back in order.
- TX_DEPTH+1 CPU writes without SPI activity → tx_full=1, txdrop=1, and the 17th byte is never transmitted.
- CTRL=0x1, then one SPI byte received → irq rises within 1 clk after the push; DATA read drains RX → irq falls; csb raised after 4 bits → no RX push.
- resetn pulsed low mid-byte with FIFOs populated → all outputs at reset values asynchronously, FIFOs empty, and the next byte frames cleanly from csb fall.

Source files
------------

// File: rtl/spi_target.sv
// spi_target: memory-mapped SPI mode-0 target (MSB first, 8-bit) with RX/TX byte FIFOs and a level irq.
// Latency: bus ready one clk after valid; SPI pins act 3 clk after a pin edge (2-FF sync + edge detect).
// Backpressure: none; a full RX discards the byte and sets rxovf, a full TX drops the CPU write and sets txdrop.
// Build option: define SPI_TARGET_IRQ_EN to include the CTRL register and irq; otherwise irq=0 and CTRL reads 0.

// spi_target_fifo: small byte FIFO, first-word-fall-through read port.
// Latency: push visible on o_dat/o_count the cycle after; pop is a same-cycle consume.
// Backpressure: push into a full FIFO is dropped unless a pop happens in the same cycle.
module spi_target_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       i_push,
  input  logic [7:0]                 i_dat,
  input  logic                       i_pop,
  output logic [7:0]                 o_dat,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_empty,
  output logic                       o_full
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic          w_do_pop;
  logic          w_do_push;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == FULL_CNT);
  assign o_count   = r_count;
  assign o_dat     = r_mem[r_rptr];
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr] <= i_dat;
  end

  // Pointers wrap naturally (power-of-two depth); count holds on simultaneous push+pop.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
      if (w_do_push && !w_do_pop)      r_count <= r_count + 1'b1;
      else if (w_do_pop && !w_do_push) r_count <= r_count - 1'b1;
    end
  end
endmodule

module spi_target #(
  parameter int         RX_DEPTH  = 16,
  parameter int         TX_DEPTH  = 16,
  parameter logic [7:0] FILL_BYTE = 8'hFF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        valid,
  output logic        ready,
  input  logic [3:0]  wstrb,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic        spi_sck,
  input  logic        spi_csb,
  input  logic        spi_mosi,
  output logic        spi_miso,
  output logic        spi_miso_oe,
  output logic        irq
);
  localparam int RX_AW = $clog2(RX_DEPTH);
  localparam int TX_AW = $clog2(TX_DEPTH);
  localparam logic [1:0] A_DATA = 2'd0;
  localparam logic [1:0] A_STAT = 2'd1;
  localparam logic [1:0] A_CTRL = 2'd2;

  // Pin synchronisers plus one delayed copy for edge detection.
  logic [1:0] r_sck_sync, r_csb_sync, r_mosi_sync;
  logic       r_sck_q, r_csb_q;
  // Bus and status state.
  logic       r_ready;
  logic       r_rxovf, r_txund, r_txdrop;
  // SPI engine state.
  logic [2:0] r_bitcnt;
  logic [7:0] r_shift_in, r_shift_out;
  logic       r_reloaded;
  logic       r_miso;

  logic        w_sck_rise, w_sck_fall, w_csb_fall, w_csb_rise, w_sel;
  logic        w_acc, w_rd, w_wr0;
  logic        w_cpu_push, w_cpu_pop, w_w1c;
  logic        w_byte_done, w_load, w_spi_pop, w_spi_push;
  logic [7:0]  w_rx_byte, w_load_byte;
  logic [7:0]  w_rx_dat, w_tx_dat;
  logic [RX_AW:0] w_rx_count;
  logic [TX_AW:0] w_tx_count;
  logic [7:0]  w_rx_cnt8;
  logic        w_rx_empty, w_rx_full, w_tx_empty, w_tx_full;
  logic        w_rxovf_set, w_txund_set, w_txdrop_set;
  logic [2:0]  w_ctrl;
  logic [31:0] w_rdata;
  logic        w_unused_bits;

  assign w_sck_rise = r_sck_sync[1] & ~r_sck_q;
  assign w_sck_fall = ~r_sck_sync[1] & r_sck_q;
  assign w_csb_fall = ~r_csb_sync[1] & r_csb_q;
  assign w_csb_rise = r_csb_sync[1] & ~r_csb_q;
  assign w_sel      = ~r_csb_sync[1];

  // A bus access completes on the ready cycle; any nonzero strobe makes it a write.
  assign w_acc      = valid & r_ready;
  assign w_rd       = w_acc & (wstrb == 4'b0000);
  assign w_wr0      = w_acc & wstrb[0];
  assign w_cpu_push = w_wr0 & (addr[3:2] == A_DATA);
  assign w_cpu_pop  = w_rd & (addr[3:2] == A_DATA) & ~w_rx_empty;
  assign w_w1c      = w_wr0 & (addr[3:2] == A_STAT);

  // A byte completes on the 8th selected rising edge; reload happens there and at csb fall.
  assign w_byte_done = w_sel & w_sck_rise & (r_bitcnt == 3'd7) & ~w_csb_fall;
  assign w_load      = w_csb_fall | w_byte_done;
  assign w_spi_pop   = w_load & ~w_tx_empty;
  assign w_spi_push  = w_byte_done;
  assign w_rx_byte   = {r_shift_in[6:0], r_mosi_sync[1]};
  assign w_load_byte = w_tx_empty ? FILL_BYTE : w_tx_dat;

  assign w_rxovf_set  = w_spi_push & w_rx_full & ~w_cpu_pop;
  assign w_txund_set  = w_load & w_tx_empty;
  assign w_txdrop_set = w_cpu_push & w_tx_full & ~w_spi_pop;

  assign w_rx_cnt8     = 8'(w_rx_count);
  assign w_unused_bits = ^{addr[31:4], addr[1:0], wdata[31:8], w_tx_count};

  spi_target_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk(clk), .resetn(resetn),
    .i_push(w_spi_push), .i_dat(w_rx_byte), .i_pop(w_cpu_pop),
    .o_dat(w_rx_dat), .o_count(w_rx_count), .o_empty(w_rx_empty), .o_full(w_rx_full)
  );

  spi_target_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk(clk), .resetn(resetn),
    .i_push(w_cpu_push), .i_dat(wdata[7:0]), .i_pop(w_spi_pop),
    .o_dat(w_tx_dat), .o_count(w_tx_count), .o_empty(w_tx_empty), .o_full(w_tx_full)
  );

  // Synchronise pins; csb resets high so the target starts deselected.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_sck_sync  <= 2'b00;
      r_csb_sync  <= 2'b11;
      r_mosi_sync <= 2'b00;
      r_sck_q     <= 1'b0;
      r_csb_q     <= 1'b1;
    end else begin
      r_sck_sync  <= {r_sck_sync[0], spi_sck};
      r_csb_sync  <= {r_csb_sync[0], spi_csb};
      r_mosi_sync <= {r_mosi_sync[0], spi_mosi};
      r_sck_q     <= r_sck_sync[1];
      r_csb_q     <= r_csb_sync[1];
    end
  end

  // One-cycle ready strobe per request.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_ready <= 1'b0;
    else         r_ready <= valid & ~r_ready;
  end

  // Sticky error flags: W1C clears, a same-cycle set wins.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rxovf  <= 1'b0;
      r_txund  <= 1'b0;
      r_txdrop <= 1'b0;
    end else begin
      r_rxovf  <= w_rxovf_set  | (r_rxovf  & ~(w_w1c & wdata[3]));
      r_txund  <= w_txund_set  | (r_txund  & ~(w_w1c & wdata[4]));
      r_txdrop <= w_txdrop_set | (r_txdrop & ~(w_w1c & wdata[5]));
    end
  end

  // SPI engine: shift in on sck rise, shift out on sck fall except the fall right after a reload.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_bitcnt    <= 3'd0;
      r_shift_in  <= 8'd0;
      r_shift_out <= 8'd0;
      r_reloaded  <= 1'b0;
      r_miso      <= 1'b0;
    end else if (w_csb_fall) begin
      r_bitcnt    <= 3'd0;
      r_reloaded  <= 1'b0;
      r_shift_out <= w_load_byte;
      r_miso      <= w_load_byte[7];
    end else if (w_csb_rise) begin
      r_bitcnt   <= 3'd0;
      r_reloaded <= 1'b0;
    end else if (w_sel && w_sck_rise) begin
      r_shift_in <= w_rx_byte;
      r_bitcnt   <= r_bitcnt + 3'd1;
      if (r_bitcnt == 3'd7) begin
        r_shift_out <= w_load_byte;
        r_miso      <= w_load_byte[7];
        r_reloaded  <= 1'b1;
      end
    end else if (w_sel && w_sck_fall) begin
      if (r_reloaded) begin
        r_reloaded <= 1'b0;
      end else begin
        r_shift_out <= {r_shift_out[6:0], 1'b0};
        r_miso      <= r_shift_out[6];
      end
    end
  end

`ifdef SPI_TARGET_IRQ_EN
  logic [2:0] r_ctrl;
  logic       r_irq;
  logic       w_err_any;

  assign w_err_any = r_rxovf | r_txund | r_txdrop;

  // CTRL holds the irq enables.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                                r_ctrl <= 3'd0;
    else if (w_wr0 && (addr[3:2] == A_CTRL))    r_ctrl <= wdata[2:0];
  end

  // Registered level interrupt.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_irq <= 1'b0;
    else         r_irq <= |(r_ctrl & {w_err_any, w_tx_empty, ~w_rx_empty});
  end

  assign w_ctrl = r_ctrl;
  assign irq    = r_irq;
`else
  assign w_ctrl = 3'd0;
  assign irq    = 1'b0;
`endif

  // Read mux, driven only during the ready cycle.
  always_comb begin
    w_rdata = 32'd0;
    if (r_ready) begin
      case (addr[3:2])
        A_DATA:  if (!w_rx_empty) w_rdata = {23'd0, 1'b1, w_rx_dat};
        A_STAT:  w_rdata = {16'd0, w_rx_cnt8, 1'b0, ~r_csb_sync[1], r_txdrop, r_txund, r_rxovf,
                            w_tx_full, w_tx_empty, ~w_rx_empty};
        A_CTRL:  w_rdata = {29'd0, w_ctrl};
        default: w_rdata = 32'd0;
      endcase
    end
  end

  assign ready       = r_ready;
  assign rdata       = w_rdata;
  assign spi_miso    = r_miso;
  assign spi_miso_oe = ~r_csb_sync[1];
endmodule
